// File: rtl/led_trail_fader.sv
// led_trail_fader: PWM comet-tail fader behind a one-hot LED scanner.
// Lit channels jump to full brightness, then decay in fixed steps.
module led_trail_fader #(
  parameter int N_LEDS     = 8,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 4096,
  parameter int DECAY_STEP = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [N_LEDS-1:0] leds_i,
  output logic [N_LEDS-1:0] pwm_o,
  output logic              active_o
);

  localparam int DIV_W =
    (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX_LVL =
    {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP =
    PWM_BITS'(DECAY_STEP);
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(DECAY_DIV - 1);

  logic [N_LEDS-1:0]   leds_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] level   [N_LEDS];
  logic [PWM_BITS-1:0] level_d [N_LEDS];
  logic [N_LEDS-1:0]   pwm_d;
  logic                any_lvl;

  assign tick = (div_cnt == DIV_LAST);

  // Shared PWM ramp and decay prescaler; both run even when disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      leds_q  <= '0;
      pwm_cnt <= '0;
      div_cnt <= '0;
    end else begin
      leds_q  <= leds_i;
      pwm_cnt <= pwm_cnt + 1'b1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  // Per-channel next level (disable > light > decay > hold) and PWM compare.
  always_comb begin
    any_lvl = 1'b0;
    pwm_d   = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      level_d[i] = level[i];
      pwm_d[i]   = en_i & (level[i] > pwm_cnt);
      if (level[i] != '0) any_lvl = 1'b1;
      if (!en_i) begin
        level_d[i] = '0;
      end else if (leds_q[i]) begin
        level_d[i] = MAX_LVL;
      end else if (tick) begin
        level_d[i] = (level[i] > STEP) ?
          level[i] - STEP : '0;
      end
    end
  end

  // Brightness level registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_LEDS; i++)
        level[i] <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++)
        level[i] <= level_d[i];
    end
  end

  // Registered outputs, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwm_o    <= '0;
      active_o <= 1'b0;
    end else begin
      pwm_o    <= pwm_d;
      active_o <= any_lvl;
    end
  end

endmodule

// File: tb/tb_led_trail_fader.sv
// tb_led_trail_fader: directed checks of the LED trail fader.
// Levels are observed hierarchically; PWM is checked cycle by cycle.
module tb_led_trail_fader;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       en_i = 1'b1;
  logic [7:0] leds_i = '0;
  logic [7:0] pwm_o;
  logic       active_o;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [7:0] plv [8];
  logic [7:0] lv  [8];

  led_trail_fader #(
    .N_LEDS(8), .PWM_BITS(8),
    .DECAY_DIV(4), .DECAY_STEP(64)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .leds_i(leds_i), .pwm_o(pwm_o),
    .active_o(active_o)
  );

  always #5 clk = ~clk;

  // Edges since reset release; pwm_cnt mirrors cyc mod 256.
  always @(posedge clk or posedge rst_i)
    if (rst_i) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic step();
    for (int i = 0; i < 8; i++) plv[i] = dut.level[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) lv[i] = dut.level[i];
  endtask

  function automatic logic [7:0] exp_pwm();
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++)
      e[i] = en_i & (plv[i] > 8'(cyc - 1));
    return e;
  endfunction

  function automatic logic exp_act();
    logic a;
    a = 1'b0;
    for (int i = 0; i < 8; i++)
      if (plv[i] != 0) a = 1'b1;
    return a;
  endfunction

  task automatic test_reset();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (pwm_o !== 8'h00 || active_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async pwm=%h act=%b want 00/0",
               pwm_o, active_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (pwm_o !== 8'h00 || active_o !== 1'b0
          || lv[0] !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle pwm=%h act=%b lv0=%0d want 00/0/0",
                 pwm_o, active_o, lv[0]);
      end
    end
  endtask

  task automatic test_reset_mid_fade();
    bit found;
    found = 0;
    leds_i = 8'h04;
    step();
    leds_i = 8'h00;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (lv[2] == 8'd191) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midfade_reach lv2=%0d want 191", lv[2]);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (pwm_o !== 8'h00 || active_o !== 1'b0) begin
      errors++;
      $display("FAIL midfade_async pwm=%h act=%b want 00/0",
               pwm_o, active_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (lv[2] !== 8'd0 || pwm_o !== 8'h00
          || active_o !== 1'b0) begin
        errors++;
        $display("FAIL midfade_after lv2=%0d pwm=%h act=%b want 0/00/0",
                 lv[2], pwm_o, active_o);
      end
    end
  endtask

  task automatic test_full_on();
    int hi;
    int bad;
    hi = 0;
    bad = 0;
    leds_i = 8'h01;
    repeat (4) step();
    for (int k = 0; k < 256; k++) begin
      step();
      if (pwm_o[0]) hi++;
      if (pwm_o[7:1] !== 7'd0) bad++;
    end
    checks++;
    if (hi != 255) begin
      errors++;
      $display("FAIL full_duty high=%0d want 255", hi);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_others bad=%0d want 0", bad);
    end
    checks++;
    if (active_o !== 1'b1 || lv[0] !== 8'd255) begin
      errors++;
      $display("FAIL full_level act=%b lv0=%0d want 1/255",
               active_o, lv[0]);
    end
    leds_i = 8'h00;
    repeat (24) step();
  endtask

  task automatic test_decay();
    logic [7:0] seq [$];
    int at [$];
    bit done;
    int zero_k;
    done = 0;
    zero_k = -1;
    leds_i = 8'h08;
    step();
    leds_i = 8'h00;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      checks++;
      if (pwm_o !== exp_pwm() || active_o !== exp_act()) begin
        errors++;
        $display("FAIL decay_pwm k=%0d pwm=%h act=%b want %h/%b",
                 k, pwm_o, active_o, exp_pwm(), exp_act());
      end
      if (lv[3] != plv[3]) begin
        seq.push_back(lv[3]);
        at.push_back(k);
        if (lv[3] == 0) zero_k = k;
      end
      if (zero_k >= 0 && k == zero_k + 1) begin
        checks++;
        if (active_o !== 1'b0) begin
          errors++;
          $display("FAIL decay_active_fall act=%b want 0", active_o);
        end
        done = 1;
      end
    end
    checks++;
    if (seq.size() != 5) begin
      errors++;
      $display("FAIL decay_seq_len got=%0d want 5", seq.size());
    end else begin
      checks++;
      if (seq[0] !== 8'd255 || seq[1] !== 8'd191
          || seq[2] !== 8'd127 || seq[3] !== 8'd63
          || seq[4] !== 8'd0) begin
        errors++;
        $display("FAIL decay_seq got=%0d,%0d,%0d,%0d,%0d want 255,191,127,63,0",
                 seq[0], seq[1], seq[2], seq[3], seq[4]);
      end
      for (int j = 2; j < 5; j++) begin
        checks++;
        if (at[j] - at[j-1] != 4) begin
          errors++;
          $display("FAIL decay_interval j=%0d got=%0d want 4",
                   j, at[j] - at[j-1]);
        end
      end
    end
  endtask

  task automatic test_set_beats_tick();
    bit found;
    found = 0;
    leds_i = 8'h20;
    step();
    leds_i = 8'h00;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (lv[5] == 8'd63) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tick_reach lv5=%0d want 63", lv[5]);
    end
    for (int k = 0; k < 4 && (cyc % 4) != 2; k++) step();
    leds_i = 8'h20;
    step();
    leds_i = 8'h00;
    checks++;
    if (lv[5] !== 8'd63) begin
      errors++;
      $display("FAIL tick_pre lv5=%0d want 63", lv[5]);
    end
    step();
    checks++;
    if (lv[5] !== 8'd255) begin
      errors++;
      $display("FAIL tick_set_wins lv5=%0d want 255", lv[5]);
    end
    repeat (24) step();
  endtask

  task automatic test_walk();
    int pos [$];
    int prev;
    int bad;
    for (int p = 0; p < 8; p++) pos.push_back(p);
    for (int p = 6; p >= 0; p--) pos.push_back(p);
    prev = -1;
    foreach (pos[n]) begin
      leds_i = 8'(1 << pos[n]);
      for (int k = 0; k < 16; k++) begin
        step();
        bad = 0;
        for (int i = 0; i < 8; i++)
          if (lv[i] > plv[i] && lv[i] != 8'd255) bad++;
        checks++;
        if (pwm_o !== exp_pwm() || bad != 0) begin
          errors++;
          $display("FAIL walk_cycle pos=%0d k=%0d pwm=%h want %h rises=%0d",
                   pos[n], k, pwm_o, exp_pwm(), bad);
        end
      end
      checks++;
      if (lv[pos[n]] !== 8'd255) begin
        errors++;
        $display("FAIL walk_head pos=%0d lv=%0d want 255",
                 pos[n], lv[pos[n]]);
      end
      if (prev >= 0) begin
        checks++;
        if (lv[prev] >= 8'd255) begin
          errors++;
          $display("FAIL walk_tail prev=%0d lv=%0d want <255",
                   prev, lv[prev]);
        end
      end
      prev = pos[n];
    end
    leds_i = 8'h00;
    repeat (24) step();
  endtask

  task automatic test_disable();
    int nz;
    leds_i = 8'hff;
    repeat (3) step();
    nz = 0;
    for (int i = 0; i < 8; i++) if (lv[i] != 8'd255) nz++;
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL dis_full notmax=%0d want 0", nz);
    end
    en_i = 1'b0;
    leds_i = 8'h00;
    for (int k = 0; k < 10; k++) begin
      step();
      nz = 0;
      for (int i = 0; i < 8; i++) if (lv[i] != 0) nz++;
      checks++;
      if (pwm_o !== 8'h00 || nz != 0
          || active_o !== exp_act()) begin
        errors++;
        $display("FAIL dis_blank k=%0d pwm=%h nz=%0d act=%b want 00/0/%b",
                 k, pwm_o, nz, active_o, exp_act());
      end
    end
    en_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (pwm_o !== 8'h00 || active_o !== 1'b0) begin
        errors++;
        $display("FAIL dis_reenable k=%0d pwm=%h act=%b want 00/0",
                 k, pwm_o, active_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_fade();
    test_full_on();
    test_decay();
    test_set_beats_tick();
    test_walk();
    test_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
